shift_right_unit: RTL and testbench
===================================

# shift_right_unit

32-bit right-shift unit producing logical (srl) and arithmetic (sra) results of one operand by a 5-bit amount, both computed every cycle. It serves the ALU shift path: a combinational barrel shifter feeding a one-cycle output register stage, with a valid flag alongside the data.

## Interface
Parameters:
- DATA_W, default 32: operand and result width.
- SH_W, default $clog2(DATA_W) = 5: shift-amount width. Derived from DATA_W; not overridden independently.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  qualifies tg/sh this cycle.
- tg  input  DATA_W  operand to shift.
- sh  input  SH_W  shift amount, unsigned, 0..DATA_W-1.
- out_valid  output  1  res_* hold a new result.
- res_logic  output  DATA_W  tg >> sh, zero-filled.
- res_arith  output  DATA_W  tg >>> sh, filled with tg[DATA_W-1].
- sticky  output  1  OR of all bits shifted out. Present only with the macro in Configuration.

## Operation
- Logical result: bit i = tg[i+sh] when i+sh < DATA_W, else 0.
- Arithmetic result: bit i = tg[i+sh] when i+sh < DATA_W, else tg[DATA_W-1].
- Non-negative tg (MSB 0): res_arith equals res_logic.
- sh = 0: both results equal tg exactly.
- sh = DATA_W-1: res_logic = {0…, tg[MSB]}; res_arith = all copies of tg[MSB].
- Implementation: barrel shifter of SH_W stages. Stage k shifts by 2^k when sh[k] = 1 and inserts a fill bit (0 for logical, tg MSB for arithmetic).
- Both results are always computed. There is no mode select.
- in_valid = 0: res_* and sticky hold their previous registered values; out_valid deasserts.

## Timing
- Latency 1 cycle: tg/sh sampled at rising edge N with in_valid = 1 → res_*, sticky, out_valid = 1 visible after edge N.
- Throughput 1 per cycle. Back-to-back valid inputs produce back-to-back results. No backpressure.
- out_valid is high for exactly the cycles following a sampled in_valid = 1.
- Reset, asynchronous and active-high: out_valid = 0, res_logic = 0, res_arith = 0, sticky = 0 immediately.
- Reset mid-stream discards the in-flight result. The first valid input after rst deasserts is returned normally.
- No combinational path from inputs to outputs.

## Configuration
- SHIFT_RIGHT_UNIT_STICKY_EN defined: the sticky port exists and is registered with the results. sticky = 1 if any tg bit at index < sh is 1; sh = 0 gives sticky = 0.
- Macro not defined: the sticky port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package shift_right_pkg: DATA_W = 32, SH_W = 5, and typedefs word_t [31:0] and shamt_t [4:0].
- One sub-module, shift_right_stage: a single barrel stage with parameter amount 2^k, inputs data, en and fill, output data. It is instantiated SH_W times per shifter.
- The output register block lives in the top module.

## Test plan
- tg 0x000000F0, sh 4 → res_logic = res_arith = 0x0000000F, sticky 0. tg 0x7FFFFFFF, sh 1 → both 0x3FFFFFFF, sticky 1.
- tg 0xFFFFFFF0, sh 4 → srl 0x0FFFFFFF, sra 0xFFFFFFFF. tg 0x80000000, sh 2 → srl 0x20000000, sra 0xE0000000.
- tg 0xFFFFFFFF, sh 8 → srl 0x00FFFFFF, sra 0xFFFFFFFF, sticky 1. tg 0x12345678, sh 0 → both 0x12345678, sticky 0.
- Boundary: tg 0x80000000, sh 31 → srl 0x00000001, sra 0xFFFFFFFF.
- Pipeline: inputs valid on 3 consecutive edges, then one idle cycle → out_valid high for exactly 3 cycles, one cycle late, with results in order. Outputs hold during the idle cycle.
- Assert rst while out_valid = 1 → all outputs 0 immediately, without waiting for a clock. The first input after release is returned correctly.

Source files
------------

// File: rtl/shift_right_pkg.sv
`default_nettype none
// ============================================================================
// Module : shift_right_pkg
// Brief  : Shared widths and types for the right-shift unit.
// Rev    : 1.0
// ============================================================================
package shift_right_pkg;

    localparam int DATA_W = 32;
    localparam int SH_W   = $clog2(DATA_W);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [SH_W-1:0]   shamt_t;

endpackage : shift_right_pkg
`default_nettype wire

// File: rtl/shift_right_unit_if.sv
`default_nettype none
// ============================================================================
// Module : shift_right_unit_if
// Brief  : Operand/result bundle for shift_right_unit.
//          sticky exists only with SHIFT_RIGHT_UNIT_STICKY_EN.
// Rev    : 1.0
// ============================================================================
interface shift_right_unit_if #(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
);

    logic              in_valid;
    logic [DATA_W-1:0] tg;
    logic [SH_W-1:0]   sh;
    logic              out_valid;
    logic [DATA_W-1:0] res_logic;
    logic [DATA_W-1:0] res_arith;
`ifdef SHIFT_RIGHT_UNIT_STICKY_EN
    logic              sticky;
`endif

    modport master (
        output in_valid, tg, sh,
`ifdef SHIFT_RIGHT_UNIT_STICKY_EN
        input  sticky,
`endif
        input  out_valid, res_logic, res_arith
    );

    modport slave (
        input  in_valid, tg, sh,
`ifdef SHIFT_RIGHT_UNIT_STICKY_EN
        output sticky,
`endif
        output out_valid, res_logic, res_arith
    );

endinterface : shift_right_unit_if
`default_nettype wire

// File: rtl/shift_right_stage.sv
`default_nettype none
// ============================================================================
// Module : shift_right_stage
// Brief  : One barrel stage: shifts right by AMOUNT when enabled, inserting fill.
// Rev    : 1.0
// ============================================================================
module shift_right_stage #(
    parameter int DATA_W = 32,
    parameter int AMOUNT = 1
) (
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic              i_en,
    input  wire logic              i_fill,
    output      logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            o_data = {{AMOUNT{i_fill}}, i_data[DATA_W-1:AMOUNT]};
        end
    end

endmodule : shift_right_stage
`default_nettype wire

// File: rtl/shift_right_unit.sv
`default_nettype none
// ============================================================================
// Module : shift_right_unit
// Brief  : Logical and arithmetic 32-bit right shifter, one registered stage.
//          Optional sticky output: define SHIFT_RIGHT_UNIT_STICKY_EN.
// Rev    : 1.0
// ============================================================================
module shift_right_unit #(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    shift_right_unit_if.slave bus
);

    import shift_right_pkg::*;

    localparam int c_msb = DATA_W - 1;

    logic [DATA_W-1:0] w_logic [0:SH_W];
    logic [DATA_W-1:0] w_arith [0:SH_W];
    logic              w_sign;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_res_logic;
    logic [DATA_W-1:0] r_res_arith;

    assign w_sign     = bus.tg[c_msb];
    assign w_logic[0] = bus.tg;
    assign w_arith[0] = bus.tg;

    // Two parallel chains share the shift amount; only the fill bit differs.
    genvar k;
    generate
        for (k = 0; k < SH_W; k++) begin : g_stage
            shift_right_stage #(
                .DATA_W (DATA_W),
                .AMOUNT (1 << k)
            ) u_logic_stage (
                .i_data (w_logic[k]),
                .i_en   (bus.sh[k]),
                .i_fill (1'b0),
                .o_data (w_logic[k+1])
            );

            shift_right_stage #(
                .DATA_W (DATA_W),
                .AMOUNT (1 << k)
            ) u_arith_stage (
                .i_data (w_arith[k]),
                .i_en   (bus.sh[k]),
                .i_fill (w_sign),
                .o_data (w_arith[k+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res_logic <= '0;
            r_res_arith <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_res_logic <= w_logic[SH_W];
                r_res_arith <= w_arith[SH_W];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.res_logic = r_res_logic;
    assign bus.res_arith = r_res_arith;

`ifdef SHIFT_RIGHT_UNIT_STICKY_EN
    logic [DATA_W-1:0] w_out_mask;
    logic              w_sticky;
    logic              r_sticky;

    // Mask selects the bit positions below sh, i.e. those shifted out.
    assign w_out_mask = ~({DATA_W{1'b1}} << bus.sh);
    assign w_sticky   = |(bus.tg & w_out_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (bus.in_valid) begin
            r_sticky <= w_sticky;
        end
    end

    assign bus.sticky = r_sticky;
`endif

endmodule : shift_right_unit
`default_nettype wire

// File: tb/tb_shift_right_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_shift_right_unit
// Brief  : Scoreboard bench for shift_right_unit with directed vectors.
// Rev    : 1.0
// ============================================================================
module tb_shift_right_unit;

    import shift_right_pkg::*;

    typedef struct {
        word_t  tg;
        shamt_t sh;
        word_t  exp_logic;
        word_t  exp_arith;
        logic   exp_sticky;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    vec_t  sb[$];
    word_t last_logic;
    word_t last_arith;
    logic  last_sticky;
    logic  exp_valid;

    shift_right_unit_if #(.DATA_W(DATA_W)) bus ();

    shift_right_unit #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic get_sticky();
`ifdef SHIFT_RIGHT_UNIT_STICKY_EN
        return bus.sticky;
`else
        return 1'b0;
`endif
    endfunction

    // Expected out_valid: the in_valid the bench drove at the previous edge.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_valid <= 1'b0;
        else     exp_valid <= bus.in_valid;
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("res_logic", bus.res_logic, e.exp_logic);
                        check("res_arith", bus.res_arith, e.exp_arith);
`ifdef SHIFT_RIGHT_UNIT_STICKY_EN
                        check("sticky", {31'd0, get_sticky()}, {31'd0, e.exp_sticky});
`endif
                        last_logic  = e.exp_logic;
                        last_arith  = e.exp_arith;
                        last_sticky = e.exp_sticky;
                    end
                end else begin
                    check("hold_logic", bus.res_logic, last_logic);
                    check("hold_arith", bus.res_arith, last_arith);
`ifdef SHIFT_RIGHT_UNIT_STICKY_EN
                    check("hold_sticky", {31'd0, get_sticky()}, {31'd0, last_sticky});
`endif
                end
            end
        end
    end

    localparam int N_VEC = 10;
    vec_t vecs [N_VEC];

    task automatic issue(input vec_t v);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.tg       = v.tg;
        bus.sh       = v.sh;
        sb.push_back(v);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.tg       = 32'hA5A5_5A5A;
        bus.sh       = 5'd13;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_res_logic"}, bus.res_logic, 32'd0);
        check({tag, "_res_arith"}, bus.res_arith, 32'd0);
`ifdef SHIFT_RIGHT_UNIT_STICKY_EN
        check({tag, "_sticky"}, {31'd0, get_sticky()}, 32'd0);
`endif
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        last_logic  = '0;
        last_arith  = '0;
        last_sticky = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.tg       = '0;
        bus.sh       = '0;

        //              tg            sh     srl           sra           sticky
        vecs[0] = '{32'h0000_00F0, 5'd4,  32'h0000_000F, 32'h0000_000F, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 5'd1,  32'h3FFF_FFFF, 32'h3FFF_FFFF, 1'b1};
        vecs[2] = '{32'hFFFF_FFF0, 5'd4,  32'h0FFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{32'h8000_0000, 5'd2,  32'h2000_0000, 32'hE000_0000, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 5'd8,  32'h00FF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{32'h1234_5678, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[6] = '{32'h8000_0000, 5'd31, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{32'h1234_5678, 5'd31, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[8] = '{32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD, 32'hFFFF_DEAD, 1'b1};
        vecs[9] = '{32'h0000_0001, 5'd1,  32'h0000_0000, 32'h0000_0000, 1'b1};

        #3;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Bursts of three back-to-back inputs separated by one idle cycle.
        for (int i = 0; i < N_VEC; i++) begin
            issue(vecs[i]);
            if ((i % 3) == 2) idle();
        end
        idle();
        idle();

        // Reset while a result is being presented.
        issue(vecs[8]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        sb.delete();
        last_logic  = '0;
        last_arith  = '0;
        last_sticky = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(vecs[3]);
        idle();

        for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
        check("drain_pending", sb.size(), 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_shift_right_unit
`default_nettype wire
